// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a one-entry holding register for gap-free frames.
// Optional parity bit is compiled in when the macro UART_TX_PARITY_EN is defined.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 32,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 byte_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_tx_frame: illegal parameter value");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic ODD = PARITY_ODD[0];
  logic par_bit;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;
  logic [DATA_BITS-1:0] shift;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 bit_done;
  logic                 stop_done;
  logic                 do_load;

  // Handshake: a byte transfers on any rising edge where s_valid && s_ready;
  // s_ready depends only on the holding register, never on s_valid.
  assign s_ready   = !hold_full;
  assign busy      = (state != IDLE) || hold_full;
  assign bit_done  = (clk_cnt == CNT_LAST);
  assign stop_done = (state == STOP) && bit_done && (bit_cnt == STOP_LAST);
  assign do_load   = hold_full && ((state == IDLE) || stop_done);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      hold_data <= '0;
      shift     <= '0;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      tx        <= 1'b1;
      byte_end  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      byte_end <= 1'b0;
      if (s_valid && s_ready) begin
        hold_full <= 1'b1;
        hold_data <= s_data;
      end

      if (state != IDLE) begin
        clk_cnt <= bit_done ? '0 : clk_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          tx <= 1'b1;
        end
        START: begin
          if (bit_done) begin
            state <= DATA;
            tx    <= shift[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx      <= par_bit;
`else
              state   <= STOP;
              tx      <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          tx <= 1'b1;
          // Registered pulse lands on the final clock of the last stop bit.
          if (bit_cnt == STOP_LAST && clk_cnt == CNT_PRE) begin
            byte_end <= 1'b1;
          end
          if (bit_done) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase

      // Load from IDLE or straight out of the final stop bit, so no idle gap.
      if (do_load) begin
        shift     <= hold_data;
        hold_full <= 1'b0;
        state     <= START;
        tx        <= 1'b0;
        clk_cnt   <= '0;
        bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
        par_bit   <= (^hold_data) ^ ODD;
`endif
      end
    end
  end

endmodule
